// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port unified memory between instruction fetch and data accesses.
// Optional `ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests instead of data-first.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wmask,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam logic [3:0] LAT = 4'(RD_LAT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                owner_q;   // 1 = data requester owns the in-flight read
  logic                if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
  logic                pick_if_d, pick_d_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_q;    // 1 = data won the most recent grant
`endif

  always_comb begin
    pick_if_d = 1'b0;
    pick_d_d  = 1'b0;
    if (state_q == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (d_req && if_req) begin
        pick_d_d  = ~last_q;
        pick_if_d = last_q;
      end else begin
        pick_d_d  = d_req;
        pick_if_d = if_req;
      end
`else
      pick_d_d  = d_req;
      pick_if_d = if_req & ~d_req;
`endif
    end
  end

  assign if_gnt    = pick_if_d;
  assign d_gnt     = pick_d_d;
  assign mem_en    = pick_if_d | pick_d_d;
  assign mem_we    = pick_d_d & d_we;
  assign mem_addr  = pick_d_d ? d_addr : (pick_if_d ? if_addr : '0);
  assign mem_wdata = pick_d_d ? d_wdata : '0;
  assign mem_wmask = pick_d_d ? d_wmask : '0;
  assign busy      = (state_q == WAIT);

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (state_q == IDLE) begin
        // Writes finish in the grant cycle; only reads occupy the port afterwards.
        if (pick_if_d || (pick_d_d && !d_we)) begin
          owner_q <= pick_d_d;
          cnt_q   <= LAT;
          state_q <= WAIT;
        end
      end else begin
        cnt_q <= cnt_q - 4'd1;
        // Last waiting cycle: mem_rdata is valid now, capture it for the owner.
        if (cnt_q == 4'd1) begin
          state_q <= IDLE;
          if (owner_q) begin
            d_rdata_q  <= mem_rdata;
            d_rvalid_q <= 1'b1;
          end else begin
            if_rdata_q  <= mem_rdata;
            if_rvalid_q <= 1'b1;
          end
        end
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (pick_if_d || pick_d_d) last_q <= pick_d_d;
`endif
    end
  end

endmodule
